// File: rtl/rpc_axi_cmd_splitter.sv
// AXI AW/AR -> RPC DRAM word-command splitter.
// Round-robin picks one address channel, then the accepted INCR burst is cut
// into commands that never cross a DRAM page and never exceed one page of words.
module rpc_axi_cmd_splitter #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int WORD_BYTES_LOG2 = 5,
  parameter int PAGE_WORDS_LOG2 = 6
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      aw_valid_i,
  output logic                                      aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]                 aw_addr_i,
  input  logic [7:0]                                aw_len_i,
  input  logic [2:0]                                aw_size_i,
  input  logic [1:0]                                aw_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]                   aw_id_i,
  input  logic                                      ar_valid_i,
  output logic                                      ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]                 ar_addr_i,
  input  logic [7:0]                                ar_len_i,
  input  logic [2:0]                                ar_size_i,
  input  logic [1:0]                                ar_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]                   ar_id_i,
  output logic                                      cmd_valid_o,
  input  logic                                      cmd_ready_i,
  output logic                                      cmd_write_o,
  output logic [AXI_ID_WIDTH-1:0]                   cmd_id_o,
  output logic [AXI_ADDR_WIDTH-WORD_BYTES_LOG2-1:0] cmd_word_addr_o,
  output logic [PAGE_WORDS_LOG2-1:0]                cmd_len_o,
  output logic                                      cmd_last_o,
  output logic                                      cmd_err_o
);

  localparam int WA = AXI_ADDR_WIDTH - WORD_BYTES_LOG2;
  localparam int PW = PAGE_WORDS_LOG2;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e                  state_q;
  logic                    lastw_q;   // previous grant went to AW
  logic                    write_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [WA-1:0]           addr_q;
  logic [8:0]              rem_q;     // words still to issue, including current command
  logic [PW-1:0]           len_q;
  logic                    last_q;
  logic                    err_q;

  logic                    grant_aw, grant_ar, accept;
  logic [WA-1:0]           sel_word;
  logic [7:0]              sel_len;
  logic [2:0]              sel_size;
  logic [1:0]              sel_burst;
  logic [AXI_ID_WIDTH-1:0] sel_id;
  logic [PW:0]             n_cur, n_d;
  logic [WA-1:0]           addr_d;
  logic [8:0]              rem_d;

  // Byte offset within a word is dropped on purpose.
  logic unused_byte_offs;
  assign unused_byte_offs = ^{aw_addr_i[WORD_BYTES_LOG2-1:0], ar_addr_i[WORD_BYTES_LOG2-1:0]};

  // Words that fit before the page boundary, capped by what is left of the burst.
  function automatic logic [PW:0] chunk(input logic [PW-1:0] off, input logic [8:0] rem);
    logic [PW:0] room;
    room = {1'b1, {PW{1'b0}}} - {1'b0, off};
    if (rem < 9'(room)) chunk = (PW+1)'(rem);
    else                chunk = room;
  endfunction

  // Round-robin arbiter; readies only in IDLE and never while reset is held.
  always_comb begin
    grant_aw = 1'b0;
    grant_ar = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      if (aw_valid_i && (!ar_valid_i || !lastw_q)) grant_aw = 1'b1;
      else if (ar_valid_i)                         grant_ar = 1'b1;
    end
  end

  assign aw_ready_o = grant_aw;
  assign ar_ready_o = grant_ar;
  assign accept     = grant_aw | grant_ar;

  // Fields of the granted channel.
  always_comb begin
    sel_word  = grant_aw ? aw_addr_i[AXI_ADDR_WIDTH-1:WORD_BYTES_LOG2]
                         : ar_addr_i[AXI_ADDR_WIDTH-1:WORD_BYTES_LOG2];
    sel_len   = grant_aw ? aw_len_i   : ar_len_i;
    sel_size  = grant_aw ? aw_size_i  : ar_size_i;
    sel_burst = grant_aw ? aw_burst_i : ar_burst_i;
    sel_id    = grant_aw ? aw_id_i    : ar_id_i;
  end

  // Next command position: fresh burst in IDLE, or advance past current command.
  always_comb begin
    n_cur = {1'b0, len_q} + 1'b1;
    if (state_q == IDLE) begin
      addr_d = sel_word;
      rem_d  = {1'b0, sel_len} + 9'd1;
    end else begin
      addr_d = addr_q + WA'(n_cur);
      rem_d  = rem_q - 9'(n_cur);
    end
    n_d = chunk(addr_d[PW-1:0], rem_d);
  end

  // Two-state splitter FSM with registered command fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lastw_q <= 1'b0;
      write_q <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= SPLIT;
          lastw_q <= grant_aw;
          write_q <= grant_aw;
          id_q    <= sel_id;
          err_q   <= (sel_burst != BURST_INCR) || (sel_size != 3'(WORD_BYTES_LOG2));
          addr_q  <= addr_d;
          rem_q   <= rem_d;
          len_q   <= PW'(n_d - 1'b1);
          last_q  <= (rem_d == 9'(n_d));
        end
        SPLIT: if (cmd_ready_i) begin
          if (last_q) begin
            state_q <= IDLE;
          end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            len_q  <= PW'(n_d - 1'b1);
            last_q <= (rem_d == 9'(n_d));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_valid_o     = (state_q == SPLIT);
  assign cmd_write_o     = write_q;
  assign cmd_id_o        = id_q;
  assign cmd_word_addr_o = addr_q;
  assign cmd_len_o       = len_q;
  assign cmd_last_o      = last_q;
  assign cmd_err_o       = err_q;

endmodule
